emb_lut_arbiter: RTL



---
 rtl/emb_lut_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/emb_lut_arbiter.sv
// -----------------------------------------------------------------------------
// emb_lut_arbiter
//
// Shares one single-port sram_v2 lookup table between two read requesters
// (pixel-path coefficient lookups) and one run-time configuration write port.
// At most one SRAM access is granted per cycle.
//
//   * cfg writes win by default, but after WR_BURST_MAX back-to-back write
//     grants a pending read gets the next slot, so reads cannot starve.
//   * The two readers are served round-robin on contention (last_rd).
//   * Read data returns through a 2-stage pipeline: the grant edge registers
//     the pending id, the following edge captures sram_datao into rspN_data
//     and pulses rspN_valid for exactly one cycle.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   req0_* / rsp0_*            requester 0 read request / response
//   req1_* / rsp1_*            requester 1 read request / response
//   cfg_wr_*                   configuration write request
//   sram_ceb, sram_web,
//   sram_addr, sram_datai      sram_v2 control / address / write data
//   sram_datao                 sram_v2 read data (one cycle after read edge)
// -----------------------------------------------------------------------------
module emb_lut_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int WR_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              cfg_wr_valid,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_wr_ready,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_datai,
  input  logic [DATA_W-1:0] sram_datao
);

  localparam int STREAK_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_BURST_MAX);

  logic [STREAK_W-1:0] wr_streak;
  logic                last_rd;   // id of the most recently granted reader
  logic                pend_v;    // read issued to the SRAM last edge
  logic                pend_id;   // which reader that read belongs to

  logic rd_any;
  logic wr_grant;
  logic rd_grant;
  logic rd_sel;

  // Grant decision. Everything is gated by reset so the SRAM sits idle and
  // no handshake completes while reset is held.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_any   = 1'b0;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    rd_sel   = 1'b0;

    rd_any = req0_valid | req1_valid;

    // Both readers valid: pick the one not served last. Otherwise pick the
    // only valid one (req1_valid alone selects 1, req0 alone selects 0).
    if (req0_valid && req1_valid) rd_sel = ~last_rd;
    else                          rd_sel = req1_valid;

    if (!reset) begin
      wr_grant = cfg_wr_valid && !((wr_streak == STREAK_MAX) && rd_any);
      rd_grant = rd_any && !wr_grant;
    end
  end

  assign cfg_wr_ready = wr_grant;
  assign req0_ready   = rd_grant && !rd_sel;
  assign req1_ready   = rd_grant &&  rd_sel;

  // SRAM pins follow the grant combinationally; idle values when nothing wins.
  always_comb begin
    sram_ceb   = 1'b1;
    sram_web   = 1'b1;
    sram_addr  = '0;
    sram_datai = '0;
    if (wr_grant) begin
      sram_ceb   = 1'b0;
      sram_web   = 1'b0;
      sram_addr  = cfg_wr_addr;
      sram_datai = cfg_wr_data;
    end else if (rd_grant) begin
      sram_ceb  = 1'b0;
      sram_addr = rd_sel ? req1_addr : req0_addr;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_streak  <= '0;
      last_rd    <= 1'b1;     // req0 wins the first contention
      pend_v     <= 1'b0;     // drops any read issued just before reset
      pend_id    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      // Streak counts consecutive write grants, saturating; any cycle without
      // a write grant restarts it.
      if (wr_grant) begin
        if (wr_streak != STREAK_MAX) wr_streak <= wr_streak + 1'b1;
      end else begin
        wr_streak <= '0;
      end

      if (rd_grant) last_rd <= rd_sel;

      pend_v  <= rd_grant;
      pend_id <= rd_sel;

      rsp0_valid <= pend_v && !pend_id;
      rsp1_valid <= pend_v &&  pend_id;
      // Data registers only load on their own response, so they hold the
      // last returned word between responses.
      if (pend_v && !pend_id) rsp0_data <= sram_datao;
      if (pend_v &&  pend_id) rsp1_data <= sram_datao;
    end
  end

endmodule
